// File: rtl/processor_ab_seq_pkg.sv
// Shared definitions for the processor_AB chain sequencer: command modes,
// chain op codes, gauss_op codes and the sequencer FSM state encoding.
package processor_ab_seq_pkg;

  // Command mode field values
  typedef enum logic [1:0] {
    MODE_MUL_MAT = 2'd0,
    MODE_EVAL    = 2'd1,
    MODE_GAUSS   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Op codes presented to every cell of the chain
  localparam logic [3:0] OP_MUL_MAT = 4'b1000;
  localparam logic [3:0] OP_EVAL    = 4'b1010;
  localparam logic [3:0] OP_GAUSS   = 4'b1110;

  // gauss_op codes
  localparam logic [1:0] GOP_NONE = 2'b00;
  localparam logic [1:0] GOP_ELIM = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_FINISH = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Per-pass control word driven to the chain
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] gauss_op;
    logic       func_a;
  } mode_ctrl_t;

  // Map a command mode onto the chain control word; reserved mode drives nothing
  function automatic mode_ctrl_t mode_ctrl(input logic [1:0] mode);
    mode_ctrl_t c;
    case (mode)
      MODE_MUL_MAT: c = '{op: OP_MUL_MAT, gauss_op: GOP_NONE, func_a: 1'b0};
      MODE_EVAL:    c = '{op: OP_EVAL,    gauss_op: GOP_ELIM, func_a: 1'b0};
      MODE_GAUSS:   c = '{op: OP_GAUSS,   gauss_op: GOP_ELIM, func_a: 1'b1};
      default:      c = '{op: 4'b0000,    gauss_op: 2'b00,    func_a: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/processor_ab_vpipe.sv
// DEPTH-stage shift register tracking which head beats are valid and which
// one is the finish beat, so the tail output can be qualified without
// looking inside the chain.
module processor_ab_vpipe
  import processor_ab_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic beat_in,
  input  logic last_in,
  output logic valid_out,
  output logic last_out
);

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] last_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] last_next;

  // Stage 0 takes the head beat, every later stage takes its predecessor
  assign valid_next[0] = beat_in;
  assign last_next[0]  = last_in;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    assign valid_next[gi] = valid_reg[gi-1];
    assign last_next[gi]  = last_reg[gi-1];
  end

  // Advance both flag pipes every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      last_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  assign valid_out = valid_reg[DEPTH-1];
  assign last_out  = last_reg[DEPTH-1];

endmodule

// File: rtl/processor_ab_seq.sv
// Sequencer for a linear chain of processor_AB cells: accepts one command,
// streams LEN words from a 1-cycle-latency RAM into the chain head framed by
// start/finish, holds the mode control word for the pass and flags result
// words leaving the chain tail.
module processor_ab_seq
  import processor_ab_seq_pkg::*;
#(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int DEPTH       = 8,
  parameter int LEN_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [LEN_W-1:0]       cmd_base,
  output logic                   rd_en,
  output logic [LEN_W-1:0]       rd_addr,
  input  logic [GF_BIT-1:0]      rd_data,
  output logic                   start_o,
  output logic                   finish_o,
  output logic [OP_CODE_LEN-1:0] op_o,
  output logic [1:0]             gauss_op_o,
  output logic                   functionA_o,
  output logic [GF_BIT-1:0]      data_o,
  output logic                   res_valid,
  output logic                   res_last,
  output logic                   busy,
  output logic                   done
);

  state_e           state_reg;
  state_e           state_next;
  logic [1:0]       mode_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] base_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             beat_reg;
  logic             start_reg;
  logic             finish_reg;
  logic             accept;
  mode_ctrl_t       ctrl;

  assign accept = cmd_valid && (state_reg == ST_IDLE);
  assign ctrl   = mode_ctrl(mode_reg);

  // Next-state selection for the pass sequence
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_mode == MODE_RSVD)  state_next = ST_DONE;
          else if (cmd_len == '0)     state_next = ST_FINISH;
          else                        state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:  if (cnt_reg == len_reg - LEN_W'(1)) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_DRAIN;
      ST_DRAIN:  if (res_last) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register plus command latch and read counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= '0;
      len_reg   <= '0;
      base_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg <= cmd_mode;
        len_reg  <= cmd_len;
        base_reg <= cmd_base;
        cnt_reg  <= '0;
      end else if (state_reg == ST_ISSUE) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
    end
  end

  // Head beat flags, aligned with the RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_reg   <= 1'b0;
      start_reg  <= 1'b0;
      finish_reg <= 1'b0;
    end else begin
      beat_reg   <= (state_reg == ST_ISSUE);
      start_reg  <= (state_reg == ST_ISSUE) && (cnt_reg == '0);
      finish_reg <= (state_reg == ST_FINISH);
    end
  end

  // Output decode; the RAM output is already registered so data_o only
  // needs gating by the delayed read strobe, which also zeroes the finish beat
  always_comb begin
    cmd_ready   = (state_reg == ST_IDLE);
    busy        = (state_reg != ST_IDLE);
    done        = (state_reg == ST_DONE);
    rd_en       = (state_reg == ST_ISSUE);
    rd_addr     = '0;
    if (state_reg == ST_ISSUE) rd_addr = base_reg + cnt_reg;
    start_o     = start_reg;
    finish_o    = finish_reg;
    data_o      = beat_reg ? rd_data : '0;
    op_o        = '0;
    gauss_op_o  = '0;
    functionA_o = 1'b0;
    if (state_reg != ST_IDLE) begin
      op_o        = OP_CODE_LEN'(ctrl.op);
      gauss_op_o  = ctrl.gauss_op;
      functionA_o = ctrl.func_a;
    end
  end

  processor_ab_vpipe #(
    .DEPTH (DEPTH)
  ) u_vpipe (
    .clk       (clk),
    .rst       (rst),
    .beat_in   (beat_reg | finish_reg),
    .last_in   (finish_reg),
    .valid_out (res_valid),
    .last_out  (res_last)
  );

endmodule

// File: tb/tb_processor_ab_seq.sv
// Self-checking bench for processor_ab_seq: directed and random commands
// checked cycle by cycle against a timeline model derived from the pass rules.
module tb_processor_ab_seq;

  localparam int GF_BIT      = 4;
  localparam int OP_CODE_LEN = 4;
  localparam int DEPTH       = 8;
  localparam int LEN_W       = 8;
  localparam int RAM_N       = 1 << LEN_W;
  localparam int ALL_W       = 3 + 1 + LEN_W + 2 + OP_CODE_LEN + 2 + 1 + GF_BIT + 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [1:0]             cmd_mode = '0;
  logic [LEN_W-1:0]       cmd_len = '0;
  logic [LEN_W-1:0]       cmd_base = '0;
  logic                   rd_en;
  logic [LEN_W-1:0]       rd_addr;
  logic [GF_BIT-1:0]      rd_data = '0;
  logic                   start_o;
  logic                   finish_o;
  logic [OP_CODE_LEN-1:0] op_o;
  logic [1:0]             gauss_op_o;
  logic                   functionA_o;
  logic [GF_BIT-1:0]      data_o;
  logic                   res_valid;
  logic                   res_last;
  logic                   busy;
  logic                   done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [GF_BIT-1:0] ram [RAM_N];

  processor_ab_seq #(
    .GF_BIT      (GF_BIT),
    .OP_CODE_LEN (OP_CODE_LEN),
    .DEPTH       (DEPTH),
    .LEN_W       (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_len     (cmd_len),
    .cmd_base    (cmd_base),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .start_o     (start_o),
    .finish_o    (finish_o),
    .op_o        (op_o),
    .gauss_op_o  (gauss_op_o),
    .functionA_o (functionA_o),
    .data_o      (data_o),
    .res_valid   (res_valid),
    .res_last    (res_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency RAM model
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [ALL_W-1:0] snapshot();
    return {cmd_ready, busy, done, rd_en, rd_addr, start_o, finish_o,
            op_o, gauss_op_o, functionA_o, data_o, res_valid, res_last};
  endfunction

  // Control word per mode: {op, gauss_op, functionA}
  function automatic logic [OP_CODE_LEN+2:0] mode_bits(input int mode);
    case (mode)
      0:       return {4'b1000, 2'b00, 1'b0};
      1:       return {4'b1010, 2'b11, 1'b0};
      2:       return {4'b1110, 2'b11, 1'b1};
      default: return '0;
    endcase
  endfunction

  // Issue one command at the current negedge (DUT idle) and check every cycle
  // of the pass plus the first idle cycle after it. With hold=1 cmd_valid stays high.
  task automatic run_cmd(input int mode, input int len, input int base, input bit hold);
    int total;
    bit stream;
    bit e_busy, e_rden, e_beat;
    logic [LEN_W-1:0] idx;
    logic [2:0] e_ctl, o_ctl;
    logic [LEN_W:0] e_rd, o_rd;
    logic [GF_BIT+1:0] e_head, o_head;
    logic [OP_CODE_LEN+2:0] e_mode, o_mode;
    logic [1:0] e_res, o_res;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready mode=%0d len=%0d: got cmd_ready=%b required=1", mode, len, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode[1:0];
    cmd_len   = len[LEN_W-1:0];
    cmd_base  = base[LEN_W-1:0];
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    stream = (mode != 3);
    total  = stream ? len + 3 + DEPTH : 1;
    for (int k = 1; k <= total + 1; k++) begin
      e_busy = (k <= total);
      e_ctl  = {!e_busy, e_busy, k == total};
      e_rden = stream && k >= 1 && k <= len;
      idx    = LEN_W'((base + k - 1) % RAM_N);
      e_rd   = {e_rden, e_rden ? idx : {LEN_W{1'b0}}};
      e_beat = stream && k >= 2 && k <= len + 1;
      idx    = LEN_W'((base + k - 2) % RAM_N);
      e_head = {stream && len > 0 && k == 2, stream && k == len + 2,
                e_beat ? ram[idx] : {GF_BIT{1'b0}}};
      e_res  = {stream && k >= 2 + DEPTH && k <= len + 2 + DEPTH, stream && k == len + 2 + DEPTH};
      e_mode = e_busy ? mode_bits(mode) : '0;

      o_ctl  = {cmd_ready, busy, done};
      o_rd   = {rd_en, rd_addr};
      o_head = {start_o, finish_o, data_o};
      o_mode = {op_o, gauss_op_o, functionA_o};
      o_res  = {res_valid, res_last};

      n_checks++;
      if (o_ctl !== e_ctl) begin
        n_fail++;
        $display("FAIL ready_busy_done mode=%0d len=%0d cyc=%0d: got=%b required=%b", mode, len, k, o_ctl, e_ctl);
      end
      n_checks++;
      if (o_rd !== e_rd) begin
        n_fail++;
        $display("FAIL rd_en_addr mode=%0d len=%0d cyc=%0d: got=%h required=%h", mode, len, k, o_rd, e_rd);
      end
      n_checks++;
      if (o_head !== e_head) begin
        n_fail++;
        $display("FAIL head_start_finish_data mode=%0d len=%0d cyc=%0d: got=%b required=%b", mode, len, k, o_head, e_head);
      end
      n_checks++;
      if (o_mode !== e_mode) begin
        n_fail++;
        $display("FAIL op_gauss_fa mode=%0d len=%0d cyc=%0d: got=%b required=%b", mode, len, k, o_mode, e_mode);
      end
      n_checks++;
      if (o_res !== e_res) begin
        n_fail++;
        $display("FAIL res_valid_last mode=%0d len=%0d cyc=%0d: got=%b required=%b", mode, len, k, o_res, e_res);
      end
      if (k <= total) @(negedge clk);
    end
    $display("cmd mode=%0d len=%0d base=%02h hold=%0d checked over %0d cycles", mode, len, base, hold, total + 1);
  endtask

  task automatic test_reset();
    logic [ALL_W-1:0] exp_all;
    exp_all = {1'b1, {(ALL_W-1){1'b0}}};
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (snapshot() !== exp_all) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got=%h required=%h", snapshot(), exp_all);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (snapshot() !== exp_all) begin
      n_fail++;
      $display("FAIL reset_held_outputs: got=%h required=%h", snapshot(), exp_all);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (snapshot() !== exp_all) begin
      n_fail++;
      $display("FAIL reset_release_idle: got=%h required=%h", snapshot(), exp_all);
    end
    $display("reset checked");
  endtask

  task automatic test_mul_mat();
    for (int i = 0; i < RAM_N; i++) ram[i] = GF_BIT'(i);
    run_cmd(0, 4, 'h10, 1'b0);
  endtask

  task automatic test_gauss();
    run_cmd(2, 3, int'($urandom_range(0, RAM_N - 1)), 1'b0);
  endtask

  task automatic test_len_zero();
    run_cmd(1, 0, 'h33, 1'b0);
    run_cmd(0, 0, 'h00, 1'b0);
  endtask

  task automatic test_wrap();
    run_cmd(0, 4, RAM_N - 2, 1'b0);
  endtask

  task automatic test_reserved_mode();
    run_cmd(3, 5, 'h20, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd(1, 3, int'($urandom_range(0, RAM_N - 1)), 1'b1);
    run_cmd(2, 2, int'($urandom_range(0, RAM_N - 1)), 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < RAM_N; i++) ram[i] = GF_BIT'($urandom);
    for (int n = 0; n < 12; n++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, RAM_N - 1)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_pass();
    logic [ALL_W-1:0] exp_all;
    exp_all = {1'b1, {(ALL_W-1){1'b0}}};
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cmd_len   = LEN_W'(10);
    cmd_base  = LEN_W'(8'h40);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midpass_issuing: got rd_en=%b required=1", rd_en);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (snapshot() !== exp_all) begin
      n_fail++;
      $display("FAIL midpass_async_reset: got=%h required=%h", snapshot(), exp_all);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < DEPTH + 16; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, res_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL midpass_no_done cyc=%0d: got busy/done/res_valid=%b required=000", k, {busy, done, res_valid});
      end
    end
    $display("reset mid-pass checked");
    run_cmd(0, int'($urandom_range(1, 12)), int'($urandom_range(0, RAM_N - 1)), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < RAM_N; i++) ram[i] = '0;
    test_reset();
    test_mul_mat();
    test_gauss();
    test_len_zero();
    test_wrap();
    test_reserved_mode();
    test_back_to_back();
    test_random();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
